// File: rtl/dmem_arbiter_if.sv
// rtl/dmem_arbiter_if.sv - requester-side handshake bundle for dmem_arbiter
interface dmem_arbiter_if #(
  parameter int ADDR_W = 32
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic [2:0]        funct3;
  logic              gnt;
  logic              rvalid;
  logic [31:0]       rdata;
  logic              err;

  modport master (
    output req, we, addr, wdata, funct3,
    input  gnt, rvalid, rdata, err
  );

  modport slave (
    input  req, we, addr, wdata, funct3,
    output gnt, rvalid, rdata, err
  );
endinterface

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-master data-memory arbiter/sequencer with access checking
// Optional round-robin tie-break on simultaneous requests: DMEM_ARB_RR_EN
module dmem_arbiter #(
  parameter int MEM_BYTES = 4096,
  parameter int ADDR_W    = 32
) (
  input  logic          clk,
  input  logic          rst,
  dmem_arbiter_if.slave m0,
  dmem_arbiter_if.slave m1,
  output logic [31:0]   mem_addr_o,
  output logic          mem_MemWrite_o,
  output logic          mem_MemRead_o,
  output logic [31:0]   mem_WriteData_o,
  output logic [2:0]    mem_funct3_o,
  input  logic [31:0]   mem_ReadData_i
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  localparam logic [ADDR_W:0] LIMIT  = (ADDR_W+1)'(MEM_BYTES);
  localparam logic [ADDR_W:0] OFS_HW = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0] OFS_W  = (ADDR_W+1)'(3);

  state_t            state_q;
  logic              win_q;
  logic              we_q;
  logic              bad_q;
  logic [31:0]       rbuf_q;
  logic [1:0]        gnt_q;
  logic [1:0]        rvalid_q;
  logic [1:0]        err_q;
  logic [1:0][31:0]  rdata_q;
  logic [31:0]       mem_addr_q;
  logic              mem_we_q;
  logic              mem_re_q;
  logic [31:0]       mem_wdata_q;
  logic [2:0]        mem_f3_q;
`ifdef DMEM_ARB_RR_EN
  logic              last_q;
`endif

  logic              win_d;
  logic              cmd_we_d;
  logic [ADDR_W-1:0] cmd_addr_d;
  logic [31:0]       cmd_wdata_d;
  logic [2:0]        cmd_f3_d;
  logic [ADDR_W:0]   cmd_last_d;
  logic              fn_ok_d;
  logic              al_ok_d;
  logic              legal_d;

  always_comb begin
    win_d = 1'b0;
    if (m0.req && m1.req) begin
`ifdef DMEM_ARB_RR_EN
      win_d = ~last_q;
`else
      win_d = 1'b0;
`endif
    end else if (m1.req) begin
      win_d = 1'b1;
    end

    cmd_we_d    = win_d ? m1.we     : m0.we;
    cmd_addr_d  = win_d ? m1.addr   : m0.addr;
    cmd_wdata_d = win_d ? m1.wdata  : m0.wdata;
    cmd_f3_d    = win_d ? m1.funct3 : m0.funct3;

    // Last byte touched, one bit wider so a wrap past 2^ADDR_W reads as out of range
    case (cmd_f3_d[1:0])
      2'b01:   cmd_last_d = {1'b0, cmd_addr_d} + OFS_HW;
      2'b10:   cmd_last_d = {1'b0, cmd_addr_d} + OFS_W;
      default: cmd_last_d = {1'b0, cmd_addr_d};
    endcase

    if (cmd_we_d)
      fn_ok_d = cmd_f3_d inside {3'b000, 3'b001, 3'b010};
    else
      fn_ok_d = cmd_f3_d inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

    case (cmd_f3_d[1:0])
      2'b01:   al_ok_d = ~cmd_addr_d[0];
      2'b10:   al_ok_d = (cmd_addr_d[1:0] == 2'b00);
      default: al_ok_d = 1'b1;
    endcase

    legal_d = fn_ok_d && al_ok_d && (cmd_last_d < LIMIT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      win_q       <= 1'b0;
      we_q        <= 1'b0;
      bad_q       <= 1'b0;
      rbuf_q      <= '0;
      gnt_q       <= '0;
      rvalid_q    <= '0;
      err_q       <= '0;
      rdata_q     <= '0;
      mem_addr_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_re_q    <= 1'b0;
      mem_wdata_q <= '0;
      mem_f3_q    <= '0;
`ifdef DMEM_ARB_RR_EN
      last_q      <= 1'b1;
`endif
    end else begin
      gnt_q    <= '0;
      rvalid_q <= '0;
      err_q    <= '0;
      mem_we_q <= 1'b0;
      mem_re_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (m0.req || m1.req) begin
            win_q        <= win_d;
            we_q         <= cmd_we_d;
            bad_q        <= ~legal_d;
            gnt_q[win_d] <= 1'b1;
            if (legal_d) begin
              // The mem_* registers double as the command latch for the ISSUE cycle
              mem_addr_q  <= 32'(cmd_addr_d);
              mem_wdata_q <= cmd_wdata_d;
              mem_f3_q    <= cmd_f3_d;
              mem_we_q    <= cmd_we_d;
              mem_re_q    <= ~cmd_we_d;
              state_q     <= ISSUE;
            end else begin
              state_q <= DONE;
            end
          end
        end
        ISSUE: state_q <= we_q ? DONE : WAIT;
        WAIT: begin
          rbuf_q  <= mem_ReadData_i;
          state_q <= DONE;
        end
        DONE: begin
          rvalid_q[win_q] <= 1'b1;
          err_q[win_q]    <= bad_q;
          rdata_q[win_q]  <= (we_q || bad_q) ? 32'd0 : rbuf_q;
`ifdef DMEM_ARB_RR_EN
          last_q          <= win_q;
`endif
          state_q         <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign m0.gnt          = gnt_q[0];
  assign m1.gnt          = gnt_q[1];
  assign m0.rvalid       = rvalid_q[0];
  assign m1.rvalid       = rvalid_q[1];
  assign m0.err          = err_q[0];
  assign m1.err          = err_q[1];
  assign m0.rdata        = rdata_q[0];
  assign m1.rdata        = rdata_q[1];
  assign mem_addr_o      = mem_addr_q;
  assign mem_MemWrite_o  = mem_we_q;
  assign mem_MemRead_o   = mem_re_q;
  assign mem_WriteData_o = mem_wdata_q;
  assign mem_funct3_o    = mem_f3_q;

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-master arbiter and sequencer in front of the byte-addressed data memory.
- The memory is a 4 KB store with a synchronous, one-cycle read and funct3-encoded width.
- Master 0 is the core load/store unit. Master 1 is the debug/loader port.
- The block serialises requests, rejects illegal accesses before they reach memory, and returns read data with a completion handshake.

Parameters:
- MEM_BYTES, 4096, memory size in bytes; any access whose last byte is at or above MEM_BYTES is an error.
- ADDR_W, 32, requester address width.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- m0_req  in  1  master 0 request; held with its command until m0_gnt
- m0_we  in  1  1 = store, 0 = load
- m0_addr  in  ADDR_W  byte address
- m0_wdata  in  32  store data, right-justified
- m0_funct3  in  3  RV32 load/store width code
- m0_gnt  out  1  one-cycle pulse: command accepted
- m0_rvalid  out  1  one-cycle pulse: transaction complete
- m0_rdata  out  32  load result, valid with m0_rvalid
- m0_err  out  1  with m0_rvalid: access rejected
- m1_*  same set as m0_*, for master 1
- mem_addr  out  32  to memory addr
- mem_MemWrite  out  1  to memory MemWrite
- mem_MemRead  out  1  to memory MemRead
- mem_WriteData  out  32  to memory WriteData
- mem_funct3  out  3  to memory funct3
- mem_ReadData  in  32  from memory; valid the cycle after the MemRead edge

Behaviour:
- Reset:
  - State goes to IDLE and the round-robin pointer to "last = m1".
  - All gnt/rvalid/err/MemRead/MemWrite outputs go to 0. All data/addr/funct3 outputs go to 0.
  - Reset mid-transaction drops the transaction; no rvalid is ever issued for it.
- All outputs are registered.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - If any req is high, pick a winner (fixed priority: m0 > m1).
  - Latch the winner's we/addr/wdata/funct3 and the winner id.
  - Pulse that master's gnt in the next cycle.
  - Go to ISSUE if the access is legal, else go to DONE with err set.
- Legality rules:
  - Loads: funct3 in {000, 001, 010, 100, 101}. Stores: funct3 in {000, 001, 010}.
  - Halfword requires addr[0] = 0. Word requires addr[1:0] = 00.
  - addr + size − 1 < MEM_BYTES, computed in ADDR_W+1 bits so wrap-around near 2^32 counts as an error.
- ISSUE:
  - Drive the mem_* command for exactly one cycle, with mem_addr = latched addr.
  - Assert MemWrite for a store or MemRead for a load, never both.
  - Store: go to DONE. Load: go to WAIT.
- WAIT: capture mem_ReadData into the winner's rdata register; go to DONE.
- DONE:
  - Pulse the winner's rvalid for one cycle, with err as decided.
  - rdata is 0 for stores and errors.
  - Set the rr pointer to the winner; return to IDLE.
- Latency:
  - Gnt arrives 1 cycle after req is sampled.
  - Store completes (rvalid) 3 cycles after req is sampled; load 4 cycles; error 2 cycles.
  - Minimum inter-grant spacing: 4 cycles for a load, 3 for a store, 2 for an error.
- The non-winning master keeps its req and waits; it is never granted while the FSM is not in IDLE.
- Requester contract: the command is stable while req is high and gnt has not yet been seen. req may drop after gnt. req asserted again in the DONE cycle is eligible in the following IDLE.
- rdata holds its value until the next completion for that master.
- mem_* data/addr hold their last values when idle. Only MemRead/MemWrite return to 0.

Optional Feature:
- DMEM_ARB_RR_EN defined:
  - Round-robin on simultaneous requests: the master not granted last wins.
  - After reset the pointer is "last = m1", so m0 wins the first tie.
- Undefined: fixed priority m0 > m1; the pointer is not implemented.
- Single-request behaviour is identical in both builds.

Test Plan:
- m0 store: word 0xDEADBEEF to addr 0x010. Then m0 load: funct3 010 from addr 0x010.
  - gnt at +1 on each request.
  - Exactly one MemWrite and one MemRead pulse.
  - Load rvalid at +4 with rdata 0xDEADBEEF, err = 0.
- m1 loads from addr 0x010, following the store above:
  - lb (000) of addr 0x013 → rdata 0xFFFFFFDE.
  - lbu (100) of the same addr → 0x000000DE.
  - lhu (101) of addr 0x012 → 0x0000DEAD.
- Illegal accesses:
  - Misaligned lw at addr 0x011.
  - sw at addr 0xFFE with MEM_BYTES = 4096.
  - Store with funct3 100.
  - Required for each: err = 1 with rvalid at +2, no MemRead/MemWrite pulse, memory contents unchanged.
- Simultaneous requests: m0 and m1 both req continuously.
  - Fixed build: m0 is granted every transaction.
  - With DMEM_ARB_RR_EN: grants alternate m0, m1, m0, m1.
- Reset mid-load: assert rst during WAIT.
  - All outputs go to 0 immediately, with no rvalid for the dropped load.
  - After release, a pending m1 req is granted normally.
- Back-to-back m1 stores at addrs 0x000–0x00C, with req re-asserted in DONE:
  - Gnt spacing of 3 cycles.
  - Each MemWrite pulse is one cycle wide.
